// File: rtl/alu_seq_pkg.sv
// Shared types and reference model for the ALU command sequencer.
package alu_seq_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_MUL  = 3'd4,
        OP_XOR  = 3'd5,
        OP_NAND = 3'd6,
        OP_NOR  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    // Computed at 32 bits; callers keep the low W bits, which gives mod 2^W results.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [31:0] r;
        case (alu_op_e'(op))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_MUL:  r = a * b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding {a, b, op, tag}; power-of-two depth, wrapping pointers.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [2*W+6:0]           i_data,
    input  logic                     i_pop,
    output logic [2*W+6:0]           o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 2*W + 7;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == DEPTH[AW:0]);
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Sequencer feeding a registered ALU one command at a time, returning tagged results.
// Optional result checker enabled by defining ALU_SEQ_CHECK_EN.
module alu_cmd_seq
    import alu_seq_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
    input  logic [3:0]   cmd_tag,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [2:0]   rsp_op,
    output logic [3:0]   rsp_tag,
    output logic         rsp_mismatch,
    output logic [7:0]   err_count,
    output logic         busy
);
    localparam int DW = 2*W + 7;

    state_e                r_state;
    state_e                w_nstate;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_rsp_clr;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic [DW-1:0]         w_head;
    logic [W-1:0]          r_alu_a;
    logic [W-1:0]          r_alu_b;
    logic [2:0]            r_alu_sel;
    logic [3:0]            r_tag;
    logic                  r_rsp_valid;
    logic [W-1:0]          r_rsp_result;
    logic [2:0]            r_rsp_op;
    logic [3:0]            r_rsp_tag;

    assign cmd_ready = !reset && !w_full;

    alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid && cmd_ready),
        .i_data  ({cmd_a, cmd_b, cmd_op, cmd_tag}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nstate;
    end

    always_comb begin
        w_nstate  = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_rsp_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_nstate = ST_ISSUE;
                end
            end
            ST_ISSUE: w_nstate = ST_WAIT;
            ST_WAIT: begin
                w_capture = 1'b1;
                w_nstate  = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    w_rsp_clr = 1'b1;
                    // Back-to-back: the next command issues on the handshake edge.
                    if (!w_empty) begin
                        w_pop    = 1'b1;
                        w_nstate = ST_ISSUE;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_op     <= '0;
            r_rsp_tag    <= '0;
        end else begin
            if (w_pop) begin
                {r_alu_a, r_alu_b, r_alu_sel, r_tag} <= w_head;
            end
            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= alu_result;
                r_rsp_op     <= r_alu_sel;
                r_rsp_tag    <= r_tag;
            end else if (w_rsp_clr) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [W-1:0] w_expect;
    logic         w_diff;
    logic         r_mismatch;
    logic [7:0]   r_err;

    assign w_expect = W'(alu_model(32'(r_alu_a), 32'(r_alu_b), r_alu_sel));
    assign w_diff   = (alu_result != w_expect);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
            r_err      <= '0;
        end else if (w_capture) begin
            r_mismatch <= w_diff;
            if (w_diff && r_err != 8'hFF) r_err <= r_err + 1'b1;
        end
    end

    assign rsp_mismatch = r_mismatch;
    assign err_count    = r_err;
`else
    assign rsp_mismatch = 1'b0;
    assign err_count    = '0;
`endif

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_op     = r_rsp_op;
    assign rsp_tag    = r_rsp_tag;
    assign busy       = (w_count != '0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a registered 4-bit ALU stand-in.
module tb_alu_cmd_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] cmd_tag;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_op;
    logic [3:0] rsp_tag;
    logic       rsp_mismatch;
    logic [7:0] err_count;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic force_zero = 1'b0;
    logic [3:0] r_alu_q;

    always #5 clk = ~clk;

    alu_cmd_seq #(.W(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy)
    );

    function automatic logic [3:0] bench_alu(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a * b;
            3'd5:    return a ^ b;
            3'd6:    return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    always @(posedge clk) r_alu_q <= bench_alu(alu_a, alu_b, alu_sel);
    assign alu_result = force_zero ? 4'h0 : r_alu_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                           input logic [3:0] tag, output int lat);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        tick;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, idx, nrsp, cyc;
        logic rdy, v, seen, stable;
        logic [7:0] got [6];
        int hs [6];

        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        tick; tick;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_result, rsp_op, rsp_tag}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", {rsp_mismatch, err_count}, 0);
        reset = 1'b0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);

        // Single ADD 7+5 tag 3, latency walk
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 4'd7; cmd_b = 4'd5; cmd_op = 3'd0; cmd_tag = 4'd3;
        tick;
        cmd_valid = 1'b0;
        chk("t1_busy", busy, 1);
        tick;
        chk("t1_alu_issue", {alu_a, alu_b, alu_sel}, {4'd7, 4'd5, 3'd0});
        chk("t1_no_rsp_e1", rsp_valid, 0);
        tick;
        chk("t1_no_rsp_e2", rsp_valid, 0);
        tick;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_result", rsp_result, 12);
        chk("t1_tag_op", {rsp_tag, rsp_op}, {4'd3, 3'd0});
        chk("t1_mismatch", rsp_mismatch, 0);
        tick;
        chk("t1_consumed", {rsp_valid, busy}, 0);
        chk("t1_alu_hold", {alu_a, alu_b, alu_sel}, {4'd7, 4'd5, 3'd0});

        // Wrap / truncate cases
        run_cmd(4'd2, 4'd5, 3'd1, 4'd1, lat);
        chk("sub_lat", lat, 3);
        chk("sub_2_5", rsp_result, 13);
        tick;
        run_cmd(4'd6, 4'd5, 3'd4, 4'd2, lat);
        chk("mul_6_5", {rsp_result, rsp_op}, {4'd14, 3'd4});
        tick;
        run_cmd(4'd0, 4'd0, 3'd7, 4'd4, lat);
        chk("nor_0_0", {rsp_result, rsp_tag}, {4'd15, 4'd4});
        tick;
        run_cmd(4'hF, 4'h3, 3'd6, 4'd5, lat);
        chk("nand_f_3", rsp_result, 4'hC);
        tick;
        run_cmd(4'hA, 4'h6, 3'd5, 4'd6, lat);
        chk("xor_a_6", rsp_result, 4'hC);
        tick;

        // Burst of 6 against a stalled response
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = 1'b1; cmd_a = 4'(idx); cmd_b = 4'd3; cmd_op = 3'd0; cmd_tag = 4'(idx + 1);
            rdy = cmd_ready;
            tick;
            if (rdy) idx++;
        end
        chk("burst_accepts", idx, 5);
        chk("burst_full", cmd_ready, 0);
        chk("burst_first_rsp", {rsp_valid, rsp_tag}, {1'b1, 4'd1});

        rsp_ready = 1'b1;
        nrsp = 0; cyc = 0;
        while (nrsp < 6 && cyc < 60) begin
            cmd_valid = (idx < 6);
            cmd_a = 4'(idx); cmd_b = 4'd3; cmd_op = 3'd0; cmd_tag = 4'(idx + 1);
            rdy = cmd_ready;
            v = rsp_valid;
            if (v) begin
                got[nrsp] = {rsp_tag, rsp_result};
                hs[nrsp]  = cyc;
            end
            tick;
            cyc++;
            if (cmd_valid && rdy) idx++;
            if (v) nrsp++;
        end
        cmd_valid = 1'b0;
        chk("burst_count", nrsp, 6);
        for (int k = 0; k < nrsp; k++) begin
            chk($sformatf("burst_rsp%0d", k), got[k], {4'(k + 1), 4'(k + 3)});
            if (k > 0) chk($sformatf("burst_gap%0d", k), hs[k] - hs[k-1], 3);
        end
        chk("burst_drained", {rsp_valid, busy}, 0);

        // Reset in WAIT with two queued
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'(i + 1); cmd_b = 4'd1; cmd_op = 3'd0; cmd_tag = 4'(9 + i);
            tick;
        end
        cmd_valid = 1'b0;
        chk("rstmid_busy", {busy, rsp_valid}, {1'b1, 1'b0});
        reset = 1'b1;
        #1;
        chk("rstmid_during", {busy, cmd_ready, rsp_valid}, 0);
        tick; tick;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (rsp_valid) seen = 1'b1;
        end
        chk("rstmid_no_rsp", seen, 0);
        chk("rstmid_after", {busy, cmd_ready}, {1'b0, 1'b1});
        run_cmd(4'd9, 4'd4, 3'd3, 4'd5, lat);
        chk("rstmid_next", {lat[3:0], rsp_result, rsp_tag}, {4'd3, 4'hD, 4'd5});
        tick;

        // Hold response 10 cycles, then one handshake dequeues one
        rsp_ready = 1'b0;
        run_cmd(4'hC, 4'hA, 3'd2, 4'hE, lat);
        chk("hold_first", {rsp_valid, rsp_result, rsp_op, rsp_tag}, {1'b1, 4'h8, 3'd2, 4'hE});
        cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd2; cmd_op = 3'd3; cmd_tag = 4'd7;
        tick;
        cmd_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if ({rsp_valid, rsp_result, rsp_op, rsp_tag} !== {1'b1, 4'h8, 3'd2, 4'hE}) stable = 1'b0;
            tick;
        end
        if ({rsp_valid, rsp_result, rsp_op, rsp_tag} !== {1'b1, 4'h8, 3'd2, 4'hE}) stable = 1'b0;
        chk("hold_stable", stable, 1);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("hold_one_deq", rsp_valid, 0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick;
            lat++;
        end
        chk("hold_second_lat", lat, 2);
        chk("hold_second", {rsp_result, rsp_op, rsp_tag}, {4'h3, 3'd3, 4'd7});
        rsp_ready = 1'b1;
        tick;
        chk("hold_idle", {rsp_valid, busy}, 0);

`ifdef ALU_SEQ_CHECK_EN
        force_zero = 1'b1;
        run_cmd(4'd1, 4'd1, 3'd0, 4'd2, lat);
        chk("chk_result", rsp_result, 0);
        chk("chk_mismatch", rsp_mismatch, 1);
        chk("chk_err_count", err_count, 1);
        tick;
        force_zero = 1'b0;
`else
        chk("nochk_err", {rsp_mismatch, err_count}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
